// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared RV32M constants, FSM state type and result selection helper.
package muldiv_sequencer_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL = 3'b000;
  localparam logic [2:0] F3_MULH = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;
  // acc holds the unsigned product, or {remainder, quotient} for divides
  function automatic logic [XLEN-1:0] sel_result(input logic [2:0] f3, input logic [2*XLEN-1:0] acc,
                                                  input logic sa, input logic sb);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    prod = (sa ^ sb) ? -acc : acc;
    quot = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    return !f3[2] ? ((f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : (f3[1] ? rem : quot);
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decode/EX-side request and result bundle for the multiply/divide unit.
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;
  logic start;
  logic [2:0] funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic flush;
  logic busy;
  logic stall;
  logic done;
  logic [XLEN-1:0] result;
  modport master(output start, funct3, op_a, op_b, flush, input busy, stall, done, result);
  modport slave(input start, funct3, op_a, op_b, flush, output busy, stall, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M unit, shift-add multiply and restoring divide over XLEN cycles.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input logic clk,
  input logic rst_n,
  muldiv_sequencer_if.slave io
);
  muldiv_state_t state_q;
  logic [2:0] f3_q;
  logic sa_q;
  logic sb_q;
  logic [4:0] cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] result_q;
  logic done_q;
  logic signed_a;
  logic signed_b;
  logic neg_a;
  logic neg_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic div_zero;
  logic div_ovf;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;
  always_comb begin
    signed_a = io.funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    signed_b = io.funct3 inside {F3_MULH, F3_DIV, F3_REM};
    neg_a = signed_a & io.op_a[XLEN-1];
    neg_b = signed_b & io.op_b[XLEN-1];
    abs_a = neg_a ? -io.op_a : io.op_a;
    abs_b = neg_b ? -io.op_b : io.op_b;
    div_zero = io.funct3[2] & (io.op_b == '0);
    div_ovf = io.funct3[2] & ~io.funct3[0] & (io.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (io.op_b == '1);
    fast_res = div_zero ? (io.funct3[1] ? io.op_a : '1) : (io.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt = {sum, acc_q[XLEN-1:1]};
    // trial subtract uses the shifted-out bit so remainders near 2^XLEN stay exact
    trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    div_nxt = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0} : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_d = (state_q == MUL) ? mul_nxt : div_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
    end else if (io.flush) begin
      state_q <= IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (io.start) begin
          f3_q <= io.funct3;
          sa_q <= neg_a;
          sb_q <= neg_b;
          cnt_q <= '0;
          acc_q <= {{XLEN{1'b0}}, abs_a};
          opb_q <= abs_b;
          if (div_zero | div_ovf) begin
            result_q <= fast_res;
            done_q <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= io.funct3[2] ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= sel_result(f3_q, acc_d, sa_q, sb_q);
            done_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
  assign io.busy = state_q != IDLE;
  assign io.stall = (io.start & (state_q == IDLE)) | (state_q == MUL) | (state_q == DIV);
  assign io.done = done_q;
  assign io.result = result_q;
endmodule
